// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for a LEGv8-subset datapath.
// Optional retired-instruction counter enabled by defining MC_PERF_CNT_EN.
`default_nettype none

module multicycle_control #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [10:0]      OPCode,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             Reg2Loc,
  output logic             ALUSrc,
  output logic [1:0]       ALUOP,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             Retire,
  output logic             Fault,
  output logic [CNT_W-1:0] InstrRetired
);

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_ADDR, S_MEM_RD, S_WB_MEM,
    S_MEM_WR, S_EXEC_R, S_WB_R, S_CBZ, S_BR, S_FAULT
  } state_t;

  typedef enum logic [2:0] {
    C_NONE, C_LD, C_ST, C_R, C_CBZ, C_B
  } cls_t;

  localparam int WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] LIMIT_M1 =
    WAIT_W'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

  state_t              state_q, state_d;
  cls_t                cls_q, cls_d, dec_cls;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                wait_state, timeout;

  always_comb begin
    dec_cls = C_NONE;
    casez (OPCode)
      11'b11111000010: dec_cls = C_LD;
      11'b11111000000: dec_cls = C_ST;
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000,
      11'b11010011011,
      11'b11010011010: dec_cls = C_R;
      11'b10110100???: dec_cls = C_CBZ;
      11'b000101?????: dec_cls = C_B;
      default:         dec_cls = C_NONE;
    endcase
  end

  assign cls_d      = (state_q == S_DECODE) ? dec_cls : cls_q;
  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  // Timeout fires on the cycle whose stall would bring the count up to the limit.
  assign timeout    = (MEM_WAIT_MAX != 0) && wait_state && !MemReady && (wait_q == LIMIT_M1);

  always_comb begin
    state_d  = state_q;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    Reg2Loc  = 1'b0;
    ALUSrc   = 1'b0;
    ALUOP    = 2'b00;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemToReg = 1'b0;
    RegWrite = 1'b0;
    Retire   = 1'b0;
    Fault    = 1'b0;
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        case (dec_cls)
          C_LD, C_ST: state_d = S_ADDR;
          C_R:        state_d = S_EXEC_R;
          C_CBZ:      state_d = S_CBZ;
          C_B:        state_d = S_BR;
          default:    state_d = S_FAULT;
        endcase
      end
      S_ADDR: begin
        ALUSrc  = 1'b1;
        Reg2Loc = (cls_q == C_ST);
        state_d = (cls_q == C_ST) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        ALUSrc  = 1'b1;
        if (MemReady)     state_d = S_WB_MEM;
        else if (timeout) state_d = S_FAULT;
      end
      S_WB_MEM: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
        Retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        Reg2Loc  = 1'b1;
        ALUSrc   = 1'b1;
        if (MemReady) begin
          Retire  = 1'b1;
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end
      S_EXEC_R: begin
        ALUOP   = 2'b10;
        state_d = S_WB_R;
      end
      S_WB_R: begin
        RegWrite = 1'b1;
        ALUOP    = 2'b10;
        Retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_CBZ: begin
        Reg2Loc = 1'b1;
        ALUOP   = 2'b01;
        Retire  = 1'b1;
        PCWrite = Zero;
        PCSrc   = 1'b1;
        state_d = S_FETCH;
      end
      S_BR: begin
        PCWrite = 1'b1;
        PCSrc   = 1'b1;
        Retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_FAULT: Fault = 1'b1;
      default: state_d = S_FAULT;
    endcase
  end

  // Any state change clears the count, which covers entry into every wait state.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q)
      wait_d = '0;
    else if (wait_state && !MemReady && (wait_q != '1))
      wait_d = wait_q + WAIT_W'(1);
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_RST;
      cls_q   <= C_NONE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      wait_q  <= wait_d;
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] retired_q;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)       retired_q <= '0;
    else if (Retire) retired_q <= retired_q + CNT_W'(1);
  end

  assign InstrRetired = retired_q;
`else
  assign InstrRetired = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control; output strobes compared as one packed vector.
`default_nettype none

module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] opcode = 11'b10001011000;
  logic        zero = 1'b0;
  logic        memready = 1'b1;
  logic        irwrite, pcwrite, pcsrc, reg2loc, alusrc, memread, memwrite;
  logic        memtoreg, regwrite, retire, fault;
  logic [1:0]  aluop;
  logic [31:0] instr_retired;

  int checks = 0;
  int errors = 0;

`ifdef MC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_B    = 11'b00010111111;

  // {IRWrite,PCWrite,PCSrc,Reg2Loc,ALUSrc,ALUOP[1:0],MemRead,MemWrite,MemToReg,RegWrite,Retire,Fault}
  localparam logic [12:0] O_IDLE    = 13'h0000;
  localparam logic [12:0] O_FETCH_W = 13'h0020;
  localparam logic [12:0] O_FETCH_R = 13'h1820;
  localparam logic [12:0] O_EXEC_R  = 13'h0080;
  localparam logic [12:0] O_WB_R    = 13'h0086;
  localparam logic [12:0] O_ADDR_LD = 13'h0100;
  localparam logic [12:0] O_ADDR_ST = 13'h0300;
  localparam logic [12:0] O_MEM_RD  = 13'h0120;
  localparam logic [12:0] O_WB_MEM  = 13'h000E;
  localparam logic [12:0] O_MEMWR_W = 13'h0310;
  localparam logic [12:0] O_MEMWR_R = 13'h0312;
  localparam logic [12:0] O_CBZ_Z1  = 13'h0E42;
  localparam logic [12:0] O_CBZ_Z0  = 13'h0642;
  localparam logic [12:0] O_BR      = 13'h0C02;
  localparam logic [12:0] O_FAULT   = 13'h0001;

  wire [12:0] outs = {irwrite, pcwrite, pcsrc, reg2loc, alusrc, aluop, memread,
                      memwrite, memtoreg, regwrite, retire, fault};

  multicycle_control #(.MEM_WAIT_MAX(15), .CNT_W(32)) dut (
    .CLK(clk), .Reset(rst), .OPCode(opcode), .Zero(zero), .MemReady(memready),
    .IRWrite(irwrite), .PCWrite(pcwrite), .PCSrc(pcsrc), .Reg2Loc(reg2loc),
    .ALUSrc(alusrc), .ALUOP(aluop), .MemRead(memread), .MemWrite(memwrite),
    .MemToReg(memtoreg), .RegWrite(regwrite), .Retire(retire), .Fault(fault),
    .InstrRetired(instr_retired)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ck(input string tag, input logic [12:0] exp);
    #1;
    checks++;
    assert (outs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, outs, exp);
    end
  endtask

  task automatic ckcnt(input string tag, input logic [31:0] exp);
    #1;
    checks++;
    assert (instr_retired === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, instr_retired, exp);
    end
  endtask

  initial begin
    // Reset, then ADD with memory always ready
    ck("reset_outs", O_IDLE);
    ckcnt("reset_cnt", 32'd0);
    cyc(); cyc();
    ck("reset_hold", O_IDLE);
    rst = 1'b0;
    cyc(); ck("add_fetch", O_FETCH_R);
    cyc(); ck("add_decode", O_IDLE);
    cyc(); ck("add_exec", O_EXEC_R);
    cyc(); ck("add_wb", O_WB_R);

    // LDUR: 2 stalls in FETCH, 3 stalls in MEM_RD, 10 cycles total
    cyc(); opcode = OP_LDUR; memready = 1'b0; ck("ld_fetch_w1", O_FETCH_W);
    cyc(); ck("ld_fetch_w2", O_FETCH_W);
    cyc(); memready = 1'b1; ck("ld_fetch_r", O_FETCH_R);
    cyc(); ck("ld_decode", O_IDLE);
    cyc(); ck("ld_addr", O_ADDR_LD);
    cyc(); memready = 1'b0; ck("ld_mem_w1", O_MEM_RD);
    cyc(); ck("ld_mem_w2", O_MEM_RD);
    cyc(); ck("ld_mem_w3", O_MEM_RD);
    cyc(); memready = 1'b1; ck("ld_mem_r", O_MEM_RD);
    cyc(); ck("ld_wb", O_WB_MEM);

    // CBZ taken, opcode changed after decode must be ignored
    cyc(); opcode = OP_CBZ; ck("cbz1_fetch", O_FETCH_R);
    cyc(); ck("cbz1_decode", O_IDLE);
    cyc(); opcode = 11'h000; zero = 1'b1; ck("cbz_taken", O_CBZ_Z1);
    cyc(); opcode = OP_CBZ; zero = 1'b0; ck("cbz2_fetch", O_FETCH_R);
    cyc(); ck("cbz2_decode", O_IDLE);
    cyc(); ck("cbz_not_taken", O_CBZ_Z0);

    // Unconditional branch
    cyc(); opcode = OP_B; ck("b_fetch", O_FETCH_R);
    cyc(); ck("b_decode", O_IDLE);
    cyc(); ck("b_br", O_BR);

    // STUR with one stall in MEM_WR
    cyc(); opcode = OP_STUR; ck("st_fetch", O_FETCH_R);
    cyc(); ck("st_decode", O_IDLE);
    cyc(); ck("st_addr", O_ADDR_ST);
    cyc(); memready = 1'b0; ck("st_mem_w", O_MEMWR_W);
    cyc(); memready = 1'b1; ck("st_mem_r", O_MEMWR_R);
    cyc(); ck("after_st_fetch", O_FETCH_R);
    ckcnt("cnt_six", PERF ? 32'd6 : 32'd0);

    // Second STUR abandoned by asynchronous reset in MEM_WR
    cyc(); ck("st2_decode", O_IDLE);
    cyc(); ck("st2_addr", O_ADDR_ST);
    cyc(); memready = 1'b0; ck("st2_mem_w", O_MEMWR_W);
    rst = 1'b1;
    ck("async_reset_drop", O_IDLE);
    ckcnt("async_reset_cnt", 32'd0);
    cyc(); ck("reset_hold2", O_IDLE);
    rst = 1'b0; memready = 1'b1; opcode = 11'h000;
    cyc(); ck("post_reset_fetch", O_FETCH_R);

    // Illegal opcode -> sticky fault, strobes stay low
    cyc(); ck("illegal_decode", O_IDLE);
    for (int i = 0; i < 20; i++) begin
      cyc(); memready = i[0]; zero = i[1]; opcode = OP_ADD;
      ck("fault_sticky", O_FAULT);
    end

    // Fetch timeout: 15 stalled cycles then FAULT
    rst = 1'b1; memready = 1'b0; opcode = OP_ADD; zero = 1'b0;
    ck("fault_cleared", O_IDLE);
    cyc(); rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cyc(); ck("to_fetch_wait", O_FETCH_W);
    end
    cyc(); ck("to_fault", O_FAULT);
    cyc(); ck("to_fault_hold", O_FAULT);

    // Ready on the 15th cycle wins; count restarts in each wait state
    rst = 1'b1; memready = 1'b0; opcode = OP_ADD;
    cyc(); rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      cyc(); ck("v_fetch_wait", O_FETCH_W);
    end
    cyc(); memready = 1'b1; ck("v_fetch_ready15", O_FETCH_R);
    cyc(); ck("v_decode", O_IDLE);
    cyc(); ck("v_exec", O_EXEC_R);
    cyc(); ck("v_wb", O_WB_R);
    cyc(); opcode = OP_LDUR; memready = 1'b0; ck("v_ld_fetch_w", O_FETCH_W);
    for (int i = 0; i < 13; i++) begin
      cyc(); ck("v_ld_fetch_w", O_FETCH_W);
    end
    cyc(); memready = 1'b1; ck("v_ld_fetch_r", O_FETCH_R);
    cyc(); ck("v_ld_decode", O_IDLE);
    cyc(); ck("v_ld_addr", O_ADDR_LD);
    for (int i = 0; i < 14; i++) begin
      cyc(); memready = 1'b0; ck("v_ld_mem_w", O_MEM_RD);
    end
    cyc(); memready = 1'b1; ck("v_ld_mem_ready15", O_MEM_RD);
    cyc(); ck("v_ld_wb", O_WB_MEM);
    cyc(); opcode = OP_B; ck("v_b_fetch", O_FETCH_R);
    cyc(); ck("v_b_decode", O_IDLE);
    cyc(); ck("v_b_br", O_BR);
    cyc(); ck("v_next_fetch", O_FETCH_R);
    ckcnt("cnt_three", PERF ? 32'd3 : 32'd0);
    rst = 1'b1;
    ckcnt("cnt_reset_clear", 32'd0);
    ck("final_reset", O_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
